// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per
// cycle, sign fix-up in a final cycle, result held until writeback takes it.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;

  // Request decode: signs, magnitudes and the two short-circuit cases.
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             overflow;
  logic             accept;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & dividend[WIDTH-1];
  assign b_neg     = signed_op & divisor[WIDTH-1];
  assign a_mag     = a_neg ? -dividend : dividend;
  assign b_mag     = b_neg ? -divisor : divisor;
  assign div_zero  = (divisor == '0);
  assign overflow  = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                     && (divisor == '1);

  assign start_ready = (state == IDLE) && !rst;
  assign busy        = (state != IDLE);
  assign accept      = start_valid & start_ready & ~flush;

  // The shifted partial remainder carries one extra bit so the compare against
  // a full-width unsigned divisor never drops the carry out of the shift.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             fits;
  logic             last;
  logic [WIDTH-1:0] rem_low;

  assign rem_shift = {rem, quo[WIDTH-1]};
  assign fits      = (rem_shift >= {1'b0, dvsr});
  assign rem_low   = rem_shift[WIDTH-1:0];
  assign rem_diff  = rem_low - dvsr;
  assign last      = (count == CW'(WIDTH - 1));

  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;

  assign q_fixed = neg_q ? -quo : quo;
  assign r_fixed = neg_r ? -rem : rem;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      rem          <= '0;
      quo          <= '0;
      dvsr         <= '0;
      is_rem       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      count        <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_rem <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dvsr   <= b_mag;
            quo    <= a_mag;
            rem    <= '0;
            count  <= '0;
            if (div_zero) begin
              result       <= op[1] ? dividend : '1;
              result_valid <= 1'b1;
              state        <= DONE;
            end else if (overflow) begin
              result       <= op[1] ? '0 : dividend;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem   <= fits ? rem_diff : rem_low;
          quo   <= {quo[WIDTH-2:0], fits};
          count <= count + CW'(1);
          if (last) state <= FIX;
        end
        FIX: begin
          result       <= is_rem ? r_fixed : q_fixed;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected results are queued at issue
// time and compared, along with latency, when result_valid rises.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .dividend     (dividend),
    .divisor      (divisor),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Independent reference using the simulator's own signed/unsigned operators.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : 32'h8000_0000;
    if (!o[0]) return o[1] ? sa % sb : sa / sb;
    return o[1] ? a % b : a / b;
  endfunction

  // Drive one request; returns just after the accept edge with inputs scrambled.
  task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    check({tag, "_ready"}, start_ready, 1'b1);
    op = o; dividend = a; divisor = b; start_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op = 2'($urandom); dividend = $urandom; divisor = $urandom;
  endtask

  // Wait for the result, check latency and value, optionally stall, then take it.
  task automatic collect(input string tag, input int exp_lat, input int hold);
    int lat;
    logic [31:0] want;
    lat = 1;
    while (!result_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_qdepth"}, exp_q.size(), 1);
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_res"}, result, want);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      check({tag, "_hold_res"}, result, want);
      check({tag, "_hold_valid"}, result_valid, 1'b1);
      check({tag, "_hold_sready"}, start_ready, 1'b0);
    end
    @(negedge clk);
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({tag, "_rv_drop"}, result_valid, 1'b0);
    check({tag, "_idle_ready"}, start_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue(tag, o, a, b, exp);
    collect(tag, lat, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check("rst_sready", start_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rvalid", result_valid, 1'b0);
    check("rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_sready", start_ready, 1'b1);

    // Main function and sign handling
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",   REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("rem_7_m2",   REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run_op("divu_max",   DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);

    // Short-circuit cases
    run_op("div_5_0",    DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0",   REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_no_ovf", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

    // Backpressure in DONE
    issue("bp", DIVU, 32'd100, 32'd7, 32'd14);
    collect("bp", 34, 10);

    // Flush at RUN count=10, then a fresh request
    issue("flush_run", DIVU, 32'd1000, 32'd3, 32'd333);
    void'(exp_q.pop_back());
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_rvalid", result_valid, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_result", result_valid, 1'b0);
    run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Flush coinciding with a result handshake discards the result
    issue("flush_hs", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    void'(exp_q.pop_back());
    @(negedge clk);
    check("flush_hs_rv", result_valid, 1'b1);
    flush = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    result_ready = 1'b0;
    check("flush_hs_drop", result_valid, 1'b0);
    check("flush_hs_busy", busy, 1'b0);

    // Flush beats a simultaneous accept
    @(negedge clk);
    op = DIVU; dividend = 32'd50; divisor = 32'd5;
    start_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    flush = 1'b0;
    check("flush_acc_busy", busy, 1'b0);

    // Random operands against the reference model
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom);
      a = $urandom;
      b = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      run_op($sformatf("rand%0d", i), o, a, b, model(o, a, b),
             (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34);
    end

    // Asynchronous reset mid-RUN
    issue("arst", DIVU, 32'd100, 32'd7, 32'd14);
    void'(exp_q.pop_back());
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_rvalid", result_valid, 1'b0);
    check("arst_sready", start_ready, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check("arst_rel_sready", start_ready, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("arst_no_result", result_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
